// File: rtl/fetch_pkg.sv
// Shared widths, PC increment and the prefetch entry layout for the instruction
// fetch path.
package fetch_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    localparam int unsigned PC_STEP = 4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instruction} entries. Circular pointers carry an extra
// wrap bit, so that full and empty can be told apart without a separate flag.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_entry_t             i_wr_data,
    output fetch_entry_t             o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;

    // NOTE: the storage is small, so it is reset as well; this keeps the head
    // outputs at zero out of reset instead of showing an unknown entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !i_flush) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

endmodule : fetch_fifo

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, reads instruction_memory combinationally
// and buffers {pc, instruction} pairs for the decoder behind a valid/ready handshake.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic [ADDR_W-1:0]        adr,
    input  logic [INSTR_W-1:0]       Instruction,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_W-1:0]       instr_data,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] w_redirect_target;
    logic              w_pop_req;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    fetch_entry_t      w_wr_entry;
    fetch_entry_t      w_head;

    // A full FIFO still accepts a new word when the head leaves in the same cycle.
    assign w_pop_req = instr_valid & instr_ready;
    assign w_pop     = w_pop_req & ~redirect_valid;
    assign w_push    = fetch_en & ~redirect_valid & (~w_full | w_pop_req);

    assign w_redirect_target = redirect_pc & ~ADDR_W'(3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_target;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
        end
    end

    assign adr        = r_fetch_pc;
    assign w_wr_entry = '{pc: r_fetch_pc, instr: Instruction};

    fetch_fifo #(
        .DEPTH     (DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (redirect_valid),
        .i_wr_data (w_wr_entry),
        .o_rd_data (w_head),
        .o_count   (fifo_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign instr_valid = ~w_empty;
    assign instr_data  = w_head.instr;
    assign instr_pc    = w_head.pc;

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational memory whose
// word i holds 32'hA000_0000 + i.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] adr;
    logic [31:0] Instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [63:0] instr_pc;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch_unit #(
        .DEPTH          (4),
        .RESET_PC       (64'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .adr            (adr),
        .Instruction    (Instruction),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .fifo_count     (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] w_word_idx;
    assign w_word_idx  = adr >> 2;
    assign Instruction = 32'hA000_0000 + w_word_idx[31:0];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [63:0] pc, input logic [31:0] data);
        check({tag, ".valid"}, 64'(instr_valid), 64'd1);
        check({tag, ".pc"}, instr_pc, pc);
        check({tag, ".data"}, 64'(instr_data), 64'(data));
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        #12;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        do_reset();
        check("rst.adr", adr, 64'h0);
        check("rst.valid", 64'(instr_valid), 64'd0);
        check("rst.count", 64'(fifo_count), 64'd0);
        check("rst.data", 64'(instr_data), 64'd0);
        check("rst.pc", instr_pc, 64'd0);

        // Streaming: one fetch and one pop per cycle.
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        step();
        check("t1.first.adr", adr, 64'h4);
        check("t1.first.count", 64'(fifo_count), 64'd1);
        check_head("t1.first", 64'h0, 32'hA000_0000);
        for (int k = 1; k < 5; k++) begin
            step();
            check_head("t1.stream", 64'(4 * k), 32'hA000_0000 + 32'(k));
            check("t1.stream.adr", adr, 64'(4 * (k + 1)));
            check("t1.stream.count", 64'(fifo_count), 64'd1);
        end

        // Back-pressure fills the FIFO, then a same-cycle pop and push.
        do_reset();
        fetch_en    = 1'b1;
        instr_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("t2.fill.count", 64'(fifo_count), 64'(k));
        end
        check("t2.full.adr", adr, 64'h10);
        step();
        check("t2.stall.adr", adr, 64'h10);
        check("t2.stall.count", 64'(fifo_count), 64'd4);
        check_head("t2.stall", 64'h0, 32'hA000_0000);
        instr_ready = 1'b1;
        step();
        check("t2.both.count", 64'(fifo_count), 64'd4);
        check("t2.both.adr", adr, 64'h14);
        check_head("t2.both", 64'h4, 32'hA000_0001);

        // Drop to 3 entries, then redirect with a pop that must be discarded.
        fetch_en = 1'b0;
        step();
        check("t3.pre.count", 64'(fifo_count), 64'd3);
        check("t3.pre.adr", adr, 64'h14);
        fetch_en       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h27;
        step();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        check("t3.redir.count", 64'(fifo_count), 64'd0);
        check("t3.redir.valid", 64'(instr_valid), 64'd0);
        check("t3.redir.adr", adr, 64'h24);
        step();
        check("t3.push.count", 64'(fifo_count), 64'd1);
        check_head("t3.push", 64'h24, 32'hA000_0009);
        check("t3.push.adr", adr, 64'h28);

        // Fetch disabled: PC frozen, FIFO drains.
        fetch_en    = 1'b0;
        instr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t4.hold.adr", adr, 64'h28);
            check("t4.hold.count", 64'(fifo_count), 64'd0);
        end
        check("t4.hold.valid", 64'(instr_valid), 64'd0);
        fetch_en = 1'b1;
        step();
        check_head("t4.resume", 64'h28, 32'hA000_000A);
        check("t4.resume.adr", adr, 64'h2C);

        // PC wrap at the top of the address space.
        instr_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        check("t5.redir.adr", adr, 64'hFFFF_FFFF_FFFF_FFF8);
        check("t5.redir.count", 64'(fifo_count), 64'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("t5.fill.count", 64'(fifo_count), (k > 4) ? 64'd4 : 64'(k));
        end
        check("t5.wrap.adr", adr, 64'h8);
        fetch_en    = 1'b0;
        instr_ready = 1'b1;
        check_head("t5.h0", 64'hFFFF_FFFF_FFFF_FFF8, 32'h9FFF_FFFE);
        step();
        check_head("t5.h1", 64'hFFFF_FFFF_FFFF_FFFC, 32'h9FFF_FFFF);
        step();
        check_head("t5.h2", 64'h0, 32'hA000_0000);
        step();
        check_head("t5.h3", 64'h4, 32'hA000_0001);
        step();
        check("t5.drain.count", 64'(fifo_count), 64'd0);

        // Asynchronous reset between edges with two entries buffered.
        fetch_en    = 1'b1;
        instr_ready = 1'b0;
        step();
        step();
        check("t6.pre.count", 64'(fifo_count), 64'd2);
        check("t6.pre.adr", adr, 64'h10);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6.async.valid", 64'(instr_valid), 64'd0);
        check("t6.async.count", 64'(fifo_count), 64'd0);
        check("t6.async.adr", adr, 64'h0);
        #3;
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_instruction_fetch_unit

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. It owns the program counter, drives the fetch address into instruction_memory, and captures the returned 32-bit word in the same cycle. Fetched {pc, instruction} pairs are buffered in a small prefetch FIFO and presented downstream to the decoder through a valid/ready handshake. It supports redirect (branch/jump) with flush and an enable for halting fetch.

Parameters:
ADDR_W, 64, fetch address / PC width; matches instruction_memory adr.
INSTR_W, 32, instruction word width.
DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
RESET_PC, 64'h0, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
fetch_en  input  1  1 = fetch permitted; 0 = hold PC, issue no pushes.
redirect_valid  input  1  one-cycle redirect request.
redirect_pc  input  ADDR_W  redirect target.
adr  output  ADDR_W  fetch address to instruction_memory; combinational copy of fetch_pc.
Instruction  input  INSTR_W  word returned combinationally by instruction_memory for adr.
instr_valid  output  1  FIFO head valid.
instr_ready  input  1  downstream accepts the head.
instr_data  output  INSTR_W  head instruction.
instr_pc  output  ADDR_W  PC of the head instruction.
fifo_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): fetch_pc = RESET_PC; FIFO empty; instr_valid = 0; fifo_count = 0; instr_data and instr_pc = 0. adr equals RESET_PC immediately.
- pop = instr_valid & instr_ready.
- push = fetch_en & !redirect_valid & (count < DEPTH | pop). A full FIFO with a same-cycle pop still pushes.
- On push, the FIFO captures {fetch_pc, Instruction} at the clock edge, and fetch_pc advances by 4 modulo 2^ADDR_W. 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Latency: a word fetched in cycle N appears at the FIFO head in cycle N+1 if the FIFO was empty.
- Redirect has priority over everything:
  - On the edge: FIFO flushed (count = 0, instr_valid = 0 next cycle); fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - No push and no pop occur that cycle; a pop asserted by downstream is discarded.
  - Back-to-back redirects: the last one wins.
- fetch_en = 0: fetch_pc frozen, no push. Pops still drain the FIFO.
- Empty: instr_valid = 0. instr_data and instr_pc hold the last head value and carry no meaning.
- fifo_count update: +1 on push only, -1 on pop only, unchanged when both or neither occur, 0 on redirect.
- Reset asserted mid-stream: all state returns to reset values asynchronously; no partial entry survives.
- Memory model: instruction_memory is a combinational read with no handshake, so there are no outstanding requests to track.

Decomposition:
- Package fetch_pkg:
  - ADDR_W and INSTR_W constants.
  - PC_STEP = 4.
  - typedef struct packed {logic [ADDR_W-1:0] pc; logic [INSTR_W-1:0] instr;} fetch_entry_t.
- Sub-module fetch_fifo: a synchronous FIFO of fetch_entry_t with push, pop, flush, count, full and empty, using circular read/write pointers with an extra wrap bit.
- The top level holds the PC register, push/pop/redirect control and the memory-side port.

Test Plan:
1. Reset then fetch_en = 1, instr_ready = 1, with memory preloaded word[i] = 32'hA000_0000+i. Required: adr steps 0, 4, 8, ... one per cycle; instr_valid rises one cycle after the first fetch; instr_pc/instr_data sequence is (0, A0000000), (4, A0000001), ...
2. instr_ready = 0 with fetch_en = 1. Required: fifo_count reaches DEPTH = 4 after 4 cycles, then adr stalls at 16. Set ready = 1: head (0, A0000000) pops, a push occurs in the same cycle, and fifo_count stays 4.
3. With the FIFO holding 3 entries, pulse redirect_valid with redirect_pc = 64'h27. Required: next cycle fifo_count = 0, instr_valid = 0, adr = 64'h24. The following cycle a push of pc 0x24 occurs.
4. fetch_en = 0 for 5 cycles with ready = 1. Required: adr constant, the FIFO drains to 0, no new entries. Re-enable: fetch resumes at the held address.
5. Redirect to 64'hFFFF_FFFF_FFFF_FFF8 with fetch_en = 1. Required: pushed pcs are ...FFF8, ...FFFC, 0x0, 0x4; fifo_count never exceeds 4.
6. Assert rst_n = 0 asynchronously between edges with 2 entries buffered. Required: instr_valid = 0, fifo_count = 0 and adr = RESET_PC before the next clock edge.
